// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, default baud constant and
// parity-mode constants reused by the transmit side.
package uart_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StWaitHigh
  } rx_state_e;

  // 100 MHz system clock at 115200 baud.
  localparam int unsigned DefaultClksPerBit = 868;

  localparam logic ParityEven = 1'b0;
  localparam logic ParityOdd  = 1'b1;

  // Rounded clock-cycles-per-bit for a given clock frequency and baud rate.
  function automatic int unsigned clks_per_bit(input int unsigned clk_hz,
                                               input int unsigned baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous FIFO with registered head output; simultaneous push and pop are
// both honoured, including when full.
module uart_rx_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_push_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_head,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam logic [PtrW:0] CountFull = (PtrW + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PtrW-1:0]  r_wr_ptr;
  logic [PtrW-1:0]  r_rd_ptr;
  logic [PtrW:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == CountFull);
  assign w_do_pop  = i_pop & ~o_empty;
  // A push into a full FIFO is accepted only when a pop frees a slot the same cycle.
  assign w_do_push = i_push & (~o_full | w_do_pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mem    <= '{default: '0};
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_push_data;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 2-FF synchroniser, 3-sample majority voting,
// false-start rejection, sticky error flags and a small receive FIFO.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DefaultClksPerBit,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY_EN    = 0,
  parameter int unsigned PARITY_ODD   = 0,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          rx_in,
  input  logic                          rx_data_clear,
  input  logic                          err_clear,
  output logic [DATA_BITS-1:0]          rx_data,
  output logic                          rx_data_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          frame_err,
  output logic                          parity_err,
  output logic                          overrun_err
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam int unsigned Mid  = CLKS_PER_BIT / 2;
  localparam logic [CntW-1:0] SampA   = CntW'(Mid - 1);
  localparam logic [CntW-1:0] SampB   = CntW'(Mid);
  localparam logic [CntW-1:0] SampC   = CntW'(Mid + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]      LastBit  = 4'(DATA_BITS - 1);
  localparam logic            LastStop = 1'(STOP_BITS - 1);
  localparam logic            HasParity = (PARITY_EN != 0);
  localparam logic            ParMode   = (PARITY_ODD != 0) ? ParityOdd : ParityEven;

  rx_state_e             r_state, w_state_d;
  logic                  r_sync1, r_sync2;
  logic [CntW-1:0]       r_cnt, w_cnt_d;
  logic [1:0]            r_samp, w_samp_d;
  logic [3:0]            r_bit_idx, w_bit_idx_d;
  logic                  r_stop_idx, w_stop_idx_d;
  logic [DATA_BITS-1:0]  r_shift, w_shift_d;
  logic                  r_par_bad, w_par_bad_d;
  logic                  r_stop_bad, w_stop_bad_d;
  logic                  r_frame_err, r_parity_err, r_overrun_err;

  logic w_maj, w_mid_end, w_bit_end, w_commit;
  logic w_set_frame, w_set_parity, w_set_overrun, w_push;
  logic w_fifo_full, w_fifo_empty;

  assign w_maj     = (r_samp[0] & r_samp[1]) | (r_samp[0] & r_sync2) | (r_samp[1] & r_sync2);
  assign w_mid_end = (r_cnt == SampC);
  assign w_bit_end = (r_cnt == CntLast);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1    <= 1'b1;
      r_sync2    <= 1'b1;
      r_state    <= StIdle;
      r_cnt      <= '0;
      r_samp     <= '0;
      r_bit_idx  <= '0;
      r_stop_idx <= 1'b0;
      r_shift    <= '0;
      r_par_bad  <= 1'b0;
      r_stop_bad <= 1'b0;
    end else begin
      r_sync1    <= rx_in;
      r_sync2    <= r_sync1;
      r_state    <= w_state_d;
      r_cnt      <= w_cnt_d;
      r_samp     <= w_samp_d;
      r_bit_idx  <= w_bit_idx_d;
      r_stop_idx <= w_stop_idx_d;
      r_shift    <= w_shift_d;
      r_par_bad  <= w_par_bad_d;
      r_stop_bad <= w_stop_bad_d;
    end
  end

  always_comb begin
    w_state_d    = r_state;
    w_cnt_d      = r_cnt + 1'b1;
    w_samp_d     = r_samp;
    w_bit_idx_d  = r_bit_idx;
    w_stop_idx_d = r_stop_idx;
    w_shift_d    = r_shift;
    w_par_bad_d  = r_par_bad;
    w_stop_bad_d = r_stop_bad;
    w_commit     = 1'b0;

    // The third sample is the live synchronised value at SampC.
    if (r_cnt == SampA) w_samp_d[0] = r_sync2;
    if (r_cnt == SampB) w_samp_d[1] = r_sync2;

    unique case (r_state)
      StIdle: begin
        w_cnt_d      = '0;
        w_bit_idx_d  = '0;
        w_stop_idx_d = 1'b0;
        w_par_bad_d  = 1'b0;
        w_stop_bad_d = 1'b0;
        if (!r_sync2) w_state_d = StStart;
      end
      StStart: begin
        if (w_mid_end && w_maj) begin
          w_state_d = StIdle;
        end else if (w_bit_end) begin
          w_state_d = StData;
          w_cnt_d   = '0;
        end
      end
      StData: begin
        if (w_mid_end) w_shift_d = {w_maj, r_shift[DATA_BITS-1:1]};
        if (w_bit_end) begin
          w_cnt_d = '0;
          if (r_bit_idx == LastBit) begin
            w_state_d = HasParity ? StParity : StStop;
          end else begin
            w_bit_idx_d = r_bit_idx + 1'b1;
          end
        end
      end
      StParity: begin
        if (w_mid_end) w_par_bad_d = w_maj ^ (^r_shift) ^ ParMode;
        if (w_bit_end) begin
          w_cnt_d   = '0;
          w_state_d = StStop;
        end
      end
      StStop: begin
        if (w_mid_end) begin
          if (!w_maj) w_stop_bad_d = 1'b1;
          if (r_stop_idx == LastStop) begin
            w_commit  = 1'b1;
            w_cnt_d   = '0;
            w_state_d = r_sync2 ? StIdle : StWaitHigh;
          end
        end else if (w_bit_end) begin
          w_cnt_d      = '0;
          w_stop_idx_d = r_stop_idx + 1'b1;
        end
      end
      StWaitHigh: begin
        w_cnt_d = '0;
        if (r_sync2) w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  // Commit priority: framing, then parity, then overrun, else push.
  assign w_set_frame   = w_commit & w_stop_bad_d;
  assign w_set_parity  = w_commit & ~w_stop_bad_d & r_par_bad;
  assign w_set_overrun = w_commit & ~w_stop_bad_d & ~r_par_bad & w_fifo_full & ~rx_data_clear;
  assign w_push        = w_commit & ~w_stop_bad_d & ~r_par_bad & ~w_set_overrun;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_frame_err   <= 1'b0;
      r_parity_err  <= 1'b0;
      r_overrun_err <= 1'b0;
    end else begin
      r_frame_err   <= w_set_frame   | (r_frame_err   & ~err_clear);
      r_parity_err  <= w_set_parity  | (r_parity_err  & ~err_clear);
      r_overrun_err <= w_set_overrun | (r_overrun_err & ~err_clear);
    end
  end

  uart_rx_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .i_push      (w_push),
    .i_push_data (r_shift),
    .i_pop       (rx_data_clear),
    .o_head      (rx_data),
    .o_full      (w_fifo_full),
    .o_empty     (w_fifo_empty),
    .o_count     (fifo_count)
  );

  assign rx_data_ready = ~w_fifo_empty;
  assign frame_err     = r_frame_err;
  assign parity_err    = r_parity_err;
  assign overrun_err   = r_overrun_err;

endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
Parametrised next-generation UART receiver for the SoC peripheral bus. It adds the following over the current fixed receiver:
- configurable frame format: data width, parity, stop-bit count
- input synchroniser
- 3-sample majority voting and false-start rejection
- error flags: framing, parity, overrun
- small receive FIFO so the CPU may lag several characters

It sits between the board RX pin and the memory-mapped UART register block.

Parameters:
CLKS_PER_BIT, 868, clock cycles per bit (100 MHz / 115200); legal range ≥ 8
DATA_BITS, 8, data bits per frame; legal 5..9
PARITY_EN, 0, 1 = parity bit present after data
PARITY_ODD, 0, 1 = odd parity, 0 = even; ignored when PARITY_EN=0
STOP_BITS, 1, number of stop bits checked; legal 1 or 2
FIFO_DEPTH, 4, receive FIFO entries; power of two, ≥ 2

Ports:
clk  in  1  system clock; all logic on rising edge
reset  in  1  asynchronous, active-high reset
rx_in  in  1  serial line, asynchronous to clk, idle high
rx_data_clear  in  1  pop strobe: removes FIFO head this cycle; ignored when empty
err_clear  in  1  clears all sticky error flags
rx_data  out  DATA_BITS  FIFO head, LSB-first assembled; valid while rx_data_ready=1
rx_data_ready  out  1  FIFO non-empty
fifo_count  out  $clog2(FIFO_DEPTH)+1  entries held
frame_err  out  1  sticky: a stop bit sampled 0
parity_err  out  1  sticky: parity mismatch
overrun_err  out  1  sticky: frame completed while FIFO full

Behaviour:
Reset values:
- Sync flops = 1; state = IDLE; counters = 0; FIFO empty.
- rx_data_ready = 0, fifo_count = 0, all error flags = 0, rx_data = 0.
- Reset mid-frame aborts the frame silently; nothing is pushed.

Synchroniser and sampling:
- rx_in passes through a 2-FF synchroniser; the FSM uses only the synchronised value.
- Bit counter is $clog2(CLKS_PER_BIT) wide.
- Each bit is taken as the majority of 3 synchronised samples at counts MID-1, MID, MID+1, where MID = CLKS_PER_BIT/2 from bit start.

FSM states:
- IDLE: a falling edge (sync=0) starts START with count 0.
- START: at MID+1, majority=1 → false start, return to IDLE with no flags; majority=0 → DATA. Bit timing is realigned so later bits are sampled at their centres.
- DATA: DATA_BITS bits shift in LSB first, one per CLKS_PER_BIT. Then go to PARITY if PARITY_EN, else STOP.
- PARITY: sample the parity bit and compare with the XOR of the data (inverted for odd).
- STOP: sample STOP_BITS stop bits. At the MID+1 sample of the last stop bit, commit the frame, then:
  - if line is high → IDLE;
  - if line is low → WAIT_HIGH.
- WAIT_HIGH: hold until sync=1 (break or line stuck low), then IDLE. No new start is accepted before then.

Commit rules, evaluated in the commit cycle:
- Any stop bit = 0 → frame_err=1, byte discarded.
- Else parity mismatch → parity_err=1, byte discarded.
- Else FIFO full and no pop this cycle → overrun_err=1, byte discarded; FIFO contents are unchanged.
- Else push.

Latency: rx_data_ready and fifo_count update 1 cycle after the commit cycle (registered FIFO).

FIFO:
- Pop and push in the same cycle: both take effect and count is unchanged. This also applies when full, with no overrun.
- Pointers wrap modulo FIFO_DEPTH.
- rx_data is the registered head and shows the new head 1 cycle after a pop.
- A pop when empty has no effect and no flag.

Error flags:
- Flags are sticky until err_clear.
- err_clear in the same cycle as a new error: the error wins and the flag stays 1.

Decomposition:
- Shared package uart_pkg holds:
  - state encodings IDLE/START/DATA/PARITY/STOP/WAIT_HIGH;
  - the default baud constant 868;
  - the function clks_per_bit(clk_hz, baud);
  - parity-mode constants shared with the future parametrised TX.
- One sub-module, uart_rx_fifo: synchronous FIFO with parameters WIDTH and DEPTH, push/pop/full/empty/count. It is reusable by the TX side.

Test Plan:
All scenarios use CLKS_PER_BIT=16.
1. 8N1 defaults: send 0xA5 then 0x3C, no pop → rx_data=0xA5, fifo_count=2, no flags. Pop → rx_data=0x3C on the next cycle.
2. False start: rx_in low for 4 cycles, then high → state returns to IDLE, fifo_count=0, no flags. A following 0x55 frame is received correctly.
3. PARITY_EN=1, PARITY_ODD=0: send 0x07 with parity bit 1 → pushed. Send 0x07 with parity bit 0 → parity_err=1, not pushed. err_clear → parity_err=0.
4. Framing/break: send 0x81 with stop=0 and hold the line low 40 bit times → frame_err=1, nothing pushed. After the line goes high, 0x42 is received normally.
5. Overrun with FIFO_DEPTH=4: send 5 frames 0x01..0x05 without popping → fifo_count=4, overrun_err=1, head 0x01. Pops yield 0x01..0x04. Repeat with a pop coinciding with the 5th commit → no overrun, 0x05 stored.
6. DATA_BITS=7, STOP_BITS=2: send 0x7F with the second stop bit 0 → frame_err=1. Also assert reset mid-DATA → all outputs return to reset values and the next frame is received cleanly.
